// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multi-cycle MIPS control FSM.
//  State encodings, extender modes, ALU ops, mux selects, opcode/funct
//  values and the one-hot instruction class produced by mc_decode.
package mc_pkg;
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [1:0] EOP_SEXT     = 2'd0;
  localparam logic [1:0] EOP_ZEXT     = 2'd1;
  localparam logic [1:0] EOP_LUI      = 2'd2;
  localparam logic [1:0] EOP_SEXT_SL2 = 2'd3;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;
  localparam logic [1:0] PC_SRC_RS  = 2'd3;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_EXT = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } cls_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
//  i_op, i_funct : IR opcode / function fields
//  o_cls         : one-hot instruction class (all zero when illegal)
//  o_illegal     : opcode or R-type funct not in the supported ISA
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic       o_illegal
);
  always_comb begin
    o_cls     = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FUNCT_ADDU, FUNCT_SUBU: o_cls.rtype_alu = 1'b1;
          FUNCT_JR:               o_cls.jr        = 1'b1;
          default:                o_illegal       = 1'b1;
        endcase
      end
      OP_ORI:  o_cls.ori = 1'b1;
      OP_LUI:  o_cls.lui = 1'b1;
      OP_LW:   o_cls.lw  = 1'b1;
      OP_SW:   o_cls.sw  = 1'b1;
      OP_BEQ:  o_cls.beq = 1'b1;
      OP_J:    o_cls.j   = 1'b1;
      OP_JAL:  o_cls.jal = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/ERR).
//  Inputs : clk, reset_n (async low), op/funct from IR, zero from ALU,
//           mem_ready from the unified memory.
//  Outputs: memory request/write/address select, IR/PC/regfile strobes,
//           PC source, extender mode, ALU op and operand selects,
//           regfile destination / write-data selects, sticky illegal flag.
//  Only state and illegal are registered; all other outputs are decoded
//  combinationally from state and inputs.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic [1:0] eop,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       illegal
);
  logic [2:0] r_state, w_next;
  logic       r_illegal, w_set_ill;
  cls_t       w_cls;
  logic       w_ill, w_rdy;
  logic       w_mem_req, w_mem_we, w_ir_wr, w_pc_wr, w_reg_wr;

  mc_decode u_dec (.i_op(op), .i_funct(funct), .o_cls(w_cls), .o_illegal(w_ill));

  assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_ill) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    i_or_d    = 1'b0;
    w_ir_wr   = 1'b0;
    w_pc_wr   = 1'b0;
    pc_src    = PC_SRC_PC4;
    eop       = EOP_SEXT;
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    w_reg_wr  = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    case (r_state)
      // IR is stale here, so nothing depends on op/funct
      S_FETCH: begin
        w_mem_req = 1'b1;
        alu_src_b = SRCB_4;
        if (w_rdy) begin
          w_ir_wr = 1'b1;
          w_pc_wr = 1'b1;
          w_next  = S_DECODE;
        end
      end
      // Branch target is computed speculatively into ALUOut every decode
      S_DECODE: begin
        alu_src_b = SRCB_EXT;
        eop       = EOP_SEXT_SL2;
        if (w_ill) begin
          w_set_ill = 1'b1;
          w_next    = S_ERR;
        end else if (w_cls.j || w_cls.jal) begin
          w_pc_wr = 1'b1;
          pc_src  = PC_SRC_JMP;
          w_next  = S_FETCH;
          // PC already holds pc+4, so the link write lands on the same edge
          if (w_cls.jal) begin
            w_reg_wr = 1'b1;
            reg_dst  = DST_RA;
            wd_sel   = WD_PC;
          end
        end else if (w_cls.jr) begin
          w_pc_wr = 1'b1;
          pc_src  = PC_SRC_RS;
          w_next  = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        w_next    = S_WB;
        if (w_cls.rtype_alu) begin
          alu_op = (funct == FUNCT_SUBU) ? ALU_SUB : ALU_ADD;
        end else if (w_cls.ori) begin
          eop       = EOP_ZEXT;
          alu_src_b = SRCB_EXT;
          alu_op    = ALU_OR;
        end else if (w_cls.lui) begin
          eop       = EOP_LUI;
          alu_src_b = SRCB_EXT;
          alu_op    = ALU_PASSB;
        end else if (w_cls.lw || w_cls.sw) begin
          alu_src_b = SRCB_EXT;
          w_next    = S_MEM;
        end else if (w_cls.beq) begin
          alu_op = ALU_SUB;
          w_next = S_FETCH;
          if (zero) begin
            w_pc_wr = 1'b1;
            pc_src  = PC_SRC_BR;
          end
        end else begin
          w_next = S_ERR;
        end
      end
      // Request, direction and address select are held until mem_ready
      S_MEM: begin
        w_mem_req = 1'b1;
        i_or_d    = 1'b1;
        w_mem_we  = w_cls.sw;
        if (w_rdy) w_next = w_cls.lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_reg_wr = 1'b1;
        reg_dst  = w_cls.rtype_alu ? DST_RD : DST_RT;
        wd_sel   = w_cls.lw ? WD_MDR : WD_ALU;
        w_next   = S_FETCH;
      end
      // ERR is absorbing; unused encodings also fall into it
      default: w_next = S_ERR;
    endcase
  end

  // Strobes are killed combinationally while reset is held so an access
  // in flight is dropped in the very cycle reset asserts.
  assign mem_req = reset_n & w_mem_req;
  assign mem_we  = reset_n & w_mem_we;
  assign ir_wr   = reset_n & w_ir_wr;
  assign pc_wr   = reset_n & w_pc_wr;
  assign reg_wr  = reset_n & w_reg_wr;
  assign illegal = r_illegal;
endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_wr, pc_wr, alu_src_a, reg_wr, illegal;
  logic [1:0] pc_src, eop, alu_src_b, reg_dst, wd_sel;
  logic [2:0] alu_op;

  mc_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .eop(eop), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_wr, pc_wr;
    logic [1:0] pc_src, eop;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_wr;
    logic [1:0] reg_dst, wd_sel;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [5:0] op, funct;
    logic       zero, rdy, rst_n;
    out_t       exp;
    string      tag;
  } vec_t;

  out_t act;
  assign act = {mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_src, eop, alu_op,
                alu_src_a, alu_src_b, reg_wr, reg_dst, wd_sel, illegal};

  vec_t tbl[$];
  logic m_ill = 1'b0;
  int   checks = 0, errors = 0;

  task automatic push(input logic [5:0] o, f, input logic z, r, rn,
                      input out_t e, input string tag);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.rst_n = rn;
    v.exp = e; v.exp.illegal = m_ill; v.tag = tag;
    tbl.push_back(v);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from its ISA role.
  // cut=1 stops inside the memory access (before mem_ready arrives).
  task automatic gen(input logic [5:0] iop, ifn, input logic bz,
                     input int fwait, mwait, input bit cut);
    out_t e;
    bit is_r, addu, subu, jr, ori, lui, lw, sw, beq, j, jal, legal;
    is_r = (iop == 6'h00);
    addu = is_r && ifn == 6'h21; subu = is_r && ifn == 6'h23; jr = is_r && ifn == 6'h08;
    ori = iop == 6'h0D; lui = iop == 6'h0F; lw = iop == 6'h23; sw = iop == 6'h2B;
    beq = iop == 6'h04; j = iop == 6'h02; jal = iop == 6'h03;
    legal = addu | subu | jr | ori | lui | lw | sw | beq | j | jal;
    // fetch: pc+4 through the ALU, IR contents irrelevant
    e = '0; e.mem_req = 1; e.alu_src_b = 1;
    for (int i = 0; i < fwait; i++)
      push(6'($urandom), 6'($urandom), 1'($urandom), 1'b0, 1'b1, e, "fetch_wait");
    e.ir_wr = 1; e.pc_wr = 1;
    push(6'($urandom), 6'($urandom), 1'($urandom), 1'b1, 1'b1, e, "fetch");
    // decode: branch target precompute, jumps resolve here
    e = '0; e.alu_src_b = 2; e.eop = 3;
    if (j || jal) begin e.pc_wr = 1; e.pc_src = 2; end
    if (jal) begin e.reg_wr = 1; e.reg_dst = 2; e.wd_sel = 2; end
    if (jr) begin e.pc_wr = 1; e.pc_src = 3; end
    push(iop, ifn, 1'($urandom), 1'($urandom), 1'b1, e, "decode");
    if (!legal) begin m_ill = 1'b1; return; end
    if (j || jal || jr) return;
    // execute
    e = '0; e.alu_src_a = 1;
    if (subu) e.alu_op = 1;
    if (ori) begin e.eop = 1; e.alu_src_b = 2; e.alu_op = 2; end
    if (lui) begin e.eop = 2; e.alu_src_b = 2; e.alu_op = 3; end
    if (lw || sw) e.alu_src_b = 2;
    if (beq) begin e.alu_op = 1; if (bz) begin e.pc_wr = 1; e.pc_src = 1; end end
    push(iop, ifn, beq ? bz : 1'($urandom), 1'($urandom), 1'b1, e, "exec");
    if (beq) return;
    if (lw || sw) begin
      e = '0; e.mem_req = 1; e.i_or_d = 1; e.mem_we = sw;
      for (int i = 0; i < mwait; i++)
        push(iop, ifn, 1'($urandom), 1'b0, 1'b1, e, "mem_wait");
      if (cut) return;
      push(iop, ifn, 1'($urandom), 1'b1, 1'b1, e, "mem");
      if (sw) return;
    end
    e = '0; e.reg_wr = 1; e.reg_dst = (addu || subu) ? 2'd1 : 2'd0; e.wd_sel = lw ? 2'd1 : 2'd0;
    push(iop, ifn, 1'($urandom), 1'($urandom), 1'b1, e, "wb");
  endtask

  // Reset holds FETCH asynchronously but suppresses every strobe.
  task automatic gen_reset(input int n);
    out_t e;
    m_ill = 1'b0;
    e = '0; e.alu_src_b = 1;
    for (int i = 0; i < n; i++)
      push(6'($urandom), 6'($urandom), 1'($urandom), 1'b1, 1'b0, e, "reset");
  endtask

  task automatic gen_err(input int n);
    for (int i = 0; i < n; i++)
      push(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b1, '0, "err");
  endtask

  task automatic apply_all();
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      op = tbl[k].op; funct = tbl[k].funct; zero = tbl[k].zero;
      mem_ready = tbl[k].rdy; reset_n = tbl[k].rst_n;
      #1;
      checks++;
      if (act !== tbl[k].exp) begin
        errors++;
        $display("FAIL %s vec %0d op=%h: got %h expected %h",
                 tbl[k].tag, k, tbl[k].op, act, tbl[k].exp);
      end
    end
    tbl.delete();
  endtask

  logic [5:0] lop[10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  logic [5:0] lfn[3]  = '{6'h21, 6'h23, 6'h08};

  initial begin
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    // directed vectors
    gen_reset(3);
    gen(6'h23, 6'h00, 1'b0, 0, 0, 0);   // lw
    gen(6'h04, 6'h11, 1'b1, 0, 0, 0);   // beq taken
    gen(6'h04, 6'h11, 1'b0, 0, 0, 0);   // beq not taken
    gen(6'h0D, 6'h05, 1'b0, 0, 0, 0);   // ori
    gen(6'h0F, 6'h05, 1'b0, 0, 0, 0);   // lui
    gen(6'h03, 6'h00, 1'b0, 0, 0, 0);   // jal
    gen(6'h02, 6'h00, 1'b0, 0, 0, 0);   // j
    gen(6'h00, 6'h08, 1'b0, 0, 0, 0);   // jr
    gen(6'h00, 6'h21, 1'b0, 0, 0, 0);   // addu
    gen(6'h00, 6'h23, 1'b0, 0, 0, 0);   // subu
    gen(6'h2B, 6'h00, 1'b0, 2, 4, 0);   // sw, slow fetch and 4 wait cycles
    gen(6'h23, 6'h00, 1'b0, 1, 2, 0);   // lw with waits
    apply_all();
    // randomized legal instruction stream
    for (int n = 0; n < 80; n++) begin
      int s;
      logic [5:0] f;
      s = $urandom_range(0, 9);
      f = (s < 3) ? lfn[s] : 6'($urandom);
      gen(lop[s], f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    apply_all();
    // illegal opcode, illegal funct, reset in the middle of a memory access
    gen(6'h3F, 6'h00, 1'b0, 0, 0, 0);
    gen_err(10);
    gen_reset(2);
    gen(6'h00, 6'h3F, 1'b0, 1, 0, 0);
    gen_err(3);
    gen_reset(1);
    gen(6'h2B, 6'h00, 1'b0, 0, 2, 1);
    gen_reset(2);
    gen(6'h23, 6'h00, 1'b0, 0, 0, 0);
    apply_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
